led_matrix_scan: RTL and testbench

Display back-end fed by the game controller's four 24-bit column buses (column_0..column_3; 8 rows x 3-bit RGB per column). It snapshots a coherent frame and serially shifts each column into the board's 24-bit shift/latch register chain (595-style). It column-multiplexes the LED matrix through active-low column enables. Runs continuously on the system clock while scan_en is high.

---
 rtl/led_matrix_scan.sv | 195 +++++++++++++++++++
 tb/tb_led_matrix_scan.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_matrix_scan.sv
`default_nettype none
// led_matrix_scan: takes a coherent snapshot of four 24-bit column buses, shifts each column
// into a 595-style shift/latch chain and multiplexes columns via active-low enables.
module led_matrix_scan #(
  parameter int CLK_DIV     = 4,
  parameter int HOLD_CYCLES = 50000
) (
  input  logic        CLK_50M,
  input  logic        RST_N,
  input  logic        scan_en,
  input  logic [23:0] column_0,
  input  logic [23:0] column_1,
  input  logic [23:0] column_2,
  input  logic [23:0] column_3,
  output logic        sr_data,
  output logic        sr_clk,
  output logic        sr_latch,
  output logic [3:0]  col_en_n,
  output logic        frame_start
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SHIFT = 3'd2,
    LATCH = 3'd3,
    HOLD  = 3'd4
  } state_t;

  localparam logic [23:0] DIV       = 24'(CLK_DIV);
  localparam logic [23:0] DIV_LAST  = 24'(CLK_DIV - 1);
  localparam logic [23:0] PH_LAST   = 24'(2 * CLK_DIV - 1);
  localparam logic [23:0] HOLD_LAST = 24'(HOLD_CYCLES - 1);

  state_t      state, state_nx;
  logic [1:0]  idx, idx_nx;
  logic [23:0] cnt, cnt_nx;
  logic [4:0]  bit_cnt, bit_nx;
  logic [23:0] sreg, sreg_nx;
  logic [23:0] shadow [4];
  logic [23:0] col_in [4];
  logic [23:0] load_word;
  logic        snap;
  logic        start_col;
  logic        sr_data_nx, sr_clk_nx, sr_latch_nx, frame_start_nx;
  logic [3:0]  col_en_nx;

  always_comb begin
    col_in[0] = column_0;
    col_in[1] = column_1;
    col_in[2] = column_2;
    col_in[3] = column_3;
  end

  // Outputs are registered from the next-cycle values so every output
  // reflects the state it belongs to in the same cycle.
  always_comb begin
    state_nx       = state;
    idx_nx         = idx;
    cnt_nx         = cnt;
    bit_nx         = bit_cnt;
    sreg_nx        = sreg;
    snap           = 1'b0;
    start_col      = 1'b0;
    load_word      = '0;
    sr_data_nx     = sr_data;
    sr_clk_nx      = sr_clk;
    sr_latch_nx    = sr_latch;
    col_en_nx      = col_en_n;
    frame_start_nx = 1'b0;

    case (state)
      IDLE: begin
        sr_clk_nx   = 1'b0;
        sr_latch_nx = 1'b0;
        sr_data_nx  = 1'b0;
        col_en_nx   = 4'hF;
        if (scan_en) begin
          idx_nx    = 2'd0;
          start_col = 1'b1;
        end
      end

      LOAD: begin
        state_nx  = SHIFT;
        cnt_nx    = '0;
        bit_nx    = '0;
        sr_clk_nx = 1'b0;
      end

      SHIFT: begin
        if (cnt == PH_LAST) begin
          cnt_nx    = '0;
          sr_clk_nx = 1'b0;
          if (bit_cnt == 5'd23) begin
            state_nx    = LATCH;
            sr_latch_nx = 1'b1;
            sr_data_nx  = 1'b0;
            col_en_nx   = 4'hF;
          end else begin
            bit_nx     = bit_cnt + 5'd1;
            sreg_nx    = {sreg[22:0], sreg[23]};
            sr_data_nx = sreg[22];
          end
        end else begin
          cnt_nx    = cnt + 24'd1;
          sr_clk_nx = (cnt_nx >= DIV);
        end
      end

      LATCH: begin
        if (cnt == DIV_LAST) begin
          state_nx    = HOLD;
          cnt_nx      = '0;
          sr_latch_nx = 1'b0;
          col_en_nx   = ~(4'b0001 << idx);
        end else begin
          cnt_nx = cnt + 24'd1;
        end
      end

      HOLD: begin
        if (cnt == HOLD_LAST) begin
          cnt_nx = '0;
          idx_nx = idx + 2'd1;
          if (scan_en) begin
            start_col = 1'b1;
          end else begin
            state_nx  = IDLE;
            col_en_nx = 4'hF;
          end
        end else begin
          cnt_nx = cnt + 24'd1;
        end
      end

      default: begin
        state_nx = IDLE;
      end
    endcase

    // Column 0 always takes a fresh snapshot straight from the buses so the
    // whole frame comes from one instant.
    if (start_col) begin
      state_nx       = LOAD;
      snap           = (idx_nx == 2'd0);
      load_word      = snap ? col_in[idx_nx] : shadow[idx_nx];
      sreg_nx        = load_word;
      sr_data_nx     = load_word[23];
      sr_clk_nx      = 1'b0;
      sr_latch_nx    = 1'b0;
      frame_start_nx = snap;
    end
  end

  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      state       <= IDLE;
      idx         <= 2'd0;
      cnt         <= '0;
      bit_cnt     <= '0;
      sreg        <= '0;
      sr_data     <= 1'b0;
      sr_clk      <= 1'b0;
      sr_latch    <= 1'b0;
      col_en_n    <= 4'hF;
      frame_start <= 1'b0;
    end else begin
      state       <= state_nx;
      idx         <= idx_nx;
      cnt         <= cnt_nx;
      bit_cnt     <= bit_nx;
      sreg        <= sreg_nx;
      sr_data     <= sr_data_nx;
      sr_clk      <= sr_clk_nx;
      sr_latch    <= sr_latch_nx;
      col_en_n    <= col_en_nx;
      frame_start <= frame_start_nx;
    end
  end

  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < 4; i++) begin
        shadow[i] <= '0;
      end
    end else if (snap) begin
      for (int i = 0; i < 4; i++) begin
        shadow[i] <= col_in[i];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_led_matrix_scan.sv
`default_nettype none
// tb_led_matrix_scan: scoreboard bench; a negedge monitor collects latched words,
// column-enable changes and frame_start times, and each test compares against expectations.
module tb_led_matrix_scan;

  localparam int CLK_DIV      = 2;
  localparam int HOLD_CYCLES  = 8;
  localparam int COL_PERIOD   = 1 + 48 * CLK_DIV + CLK_DIV + HOLD_CYCLES;
  localparam int FRAME_PERIOD = 4 * COL_PERIOD;
  localparam int LIT_TIME     = HOLD_CYCLES + 1 + 48 * CLK_DIV;
  localparam int LOAD_TO_HOLD = 1 + 48 * CLK_DIV + CLK_DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        scan_en = 1'b0;
  logic [23:0] column_0 = '0, column_1 = '0, column_2 = '0, column_3 = '0;
  logic        sr_data, sr_clk, sr_latch, frame_start;
  logic [3:0]  col_en_n;

  always #5 clk = ~clk;

  led_matrix_scan #(.CLK_DIV(CLK_DIV), .HOLD_CYCLES(HOLD_CYCLES)) dut (
    .CLK_50M(clk), .RST_N(rst_n), .scan_en(scan_en),
    .column_0(column_0), .column_1(column_1), .column_2(column_2), .column_3(column_3),
    .sr_data(sr_data), .sr_clk(sr_clk), .sr_latch(sr_latch),
    .col_en_n(col_en_n), .frame_start(frame_start)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  logic [23:0] obs_word [$];
  int          obs_nedge [$];
  int          obs_llen [$];
  logic [3:0]  obs_col [$];
  int          obs_colt [$];
  int          obs_fs [$];
  logic [23:0] exp_word [$];
  logic [3:0]  exp_col [$];

  int rst_rises = 0;
  int total_rises = 0;
  bit latch_blank_bad = 0;

  initial begin : monitor
    logic        prev_clk, prev_latch;
    logic [3:0]  prev_col;
    logic [23:0] acc;
    int          nedges, latch_len;
    prev_clk = 0; prev_latch = 0; prev_col = 4'hF; acc = '0; nedges = 0; latch_len = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (sr_clk && !prev_clk) begin
        total_rises++;
        if (!rst_n) rst_rises++;
      end
      if (!rst_n) begin
        nedges = 0; latch_len = 0; prev_latch = 0; prev_col = 4'hF;
      end else begin
        if (sr_clk && !prev_clk) begin
          acc = {acc[22:0], sr_data};
          nedges++;
        end
        if (sr_latch) begin
          latch_len++;
          if (col_en_n !== 4'hF) latch_blank_bad = 1;
        end
        if (!sr_latch && prev_latch) begin
          obs_word.push_back(acc);
          obs_nedge.push_back(nedges);
          obs_llen.push_back(latch_len);
          nedges = 0; latch_len = 0;
        end
        if (col_en_n !== prev_col) begin
          obs_col.push_back(col_en_n);
          obs_colt.push_back(cyc);
        end
        if (frame_start) obs_fs.push_back(cyc);
        prev_latch = sr_latch;
        prev_col   = col_en_n;
      end
      prev_clk = sr_clk;
    end
  end

  function automatic bit have(input int which, input int n);
    case (which)
      0:       return obs_word.size() >= n;
      1:       return obs_col.size() >= n;
      default: return obs_fs.size() >= n;
    endcase
  endfunction

  task automatic wait_for(input int which, input int n, input int limit, output bit ok);
    for (int i = 0; i < limit && !have(which, n); i++) @(negedge clk);
    ok = have(which, n);
  endtask

  task automatic restart(input logic [23:0] c0, c1, c2, c3);
    rst_n = 1'b0;
    scan_en = 1'b1;
    repeat (3) @(negedge clk);
    obs_word.delete(); obs_nedge.delete(); obs_llen.delete();
    obs_col.delete(); obs_colt.delete(); obs_fs.delete();
    exp_word.delete(); exp_col.delete();
    latch_blank_bad = 0;
    column_0 = c0; column_1 = c1; column_2 = c2; column_3 = c3;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; scan_en = 1'b1;
    column_0 = 24'hFFFFFF; column_1 = 24'h123456;
    rst_rises = 0;
    repeat (20) @(negedge clk);
    n_vec++;
    if ({col_en_n, sr_clk, sr_latch, sr_data, frame_start} !== 8'hF0) begin
      n_err++;
      $display("FAIL reset_outputs: got col=%b clk=%b lat=%b dat=%b fs=%b, want col=1111 others 0",
               col_en_n, sr_clk, sr_latch, sr_data, frame_start);
    end
    n_vec++;
    if (rst_rises !== 0) begin
      n_err++;
      $display("FAIL reset_no_sr_clk: got %0d rising edges, want 0", rst_rises);
    end
  endtask

  task automatic test_shift_data();
    bit ok;
    logic [23:0] w, e;
    int t0, t1;
    restart(24'hA5A5A5, 24'h0, 24'h0, 24'h0);
    exp_word.push_back(24'hA5A5A5);
    repeat (3) exp_word.push_back(24'h000000);
    wait_for(0, 4, FRAME_PERIOD + 50, ok);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL shift_timeout: got %0d words, want 4", obs_word.size());
    end
    for (int i = 0; i < 4 && obs_word.size() > 0; i++) begin
      w = obs_word.pop_front(); e = exp_word.pop_front();
      n_vec++;
      if (w !== e) begin
        n_err++;
        $display("FAIL shift_word%0d: got %h, want %h", i, w, e);
      end
      n_vec++;
      if (obs_nedge[0] !== 24) begin
        n_err++;
        $display("FAIL shift_edges%0d: got %0d, want 24", i, obs_nedge[0]);
      end
      void'(obs_nedge.pop_front());
      n_vec++;
      if (obs_llen[0] !== CLK_DIV) begin
        n_err++;
        $display("FAIL latch_len%0d: got %0d, want %0d", i, obs_llen[0], CLK_DIV);
      end
      void'(obs_llen.pop_front());
    end
    n_vec++;
    if (latch_blank_bad !== 1'b0) begin
      n_err++;
      $display("FAIL latch_blank: got col_en_n not 1111 during latch, want 1111");
    end
    if (obs_col.size() >= 2) begin
      t0 = obs_colt[0]; t1 = obs_colt[1];
      n_vec++;
      if (obs_col[0] !== 4'b1110 || obs_col[1] !== 4'hF) begin
        n_err++;
        $display("FAIL first_column: got %b then %b, want 1110 then 1111", obs_col[0], obs_col[1]);
      end
      n_vec++;
      if (t1 - t0 !== LIT_TIME) begin
        n_err++;
        $display("FAIL lit_time: got %0d cycles, want %0d", t1 - t0, LIT_TIME);
      end
    end else begin
      n_vec++; n_err++;
      $display("FAIL first_column: got %0d enable changes, want >=2", obs_col.size());
    end
  endtask

  task automatic test_scan_order();
    bit ok1, ok2;
    int t [9];
    int fs0, fs1;
    logic [3:0] v, e;
    restart(24'h010203, 24'h040506, 24'h070809, 24'h0A0B0C);
    exp_col.push_back(4'b1110); exp_col.push_back(4'hF);
    exp_col.push_back(4'b1101); exp_col.push_back(4'hF);
    exp_col.push_back(4'b1011); exp_col.push_back(4'hF);
    exp_col.push_back(4'b0111); exp_col.push_back(4'hF);
    exp_col.push_back(4'b1110);
    wait_for(1, 9, FRAME_PERIOD + LOAD_TO_HOLD + 50, ok1);
    wait_for(2, 2, 10, ok2);
    n_vec++;
    if (!(ok1 && ok2)) begin
      n_err++;
      $display("FAIL scan_timeout: got %0d enables %0d frames, want 9 and 2", obs_col.size(), obs_fs.size());
      return;
    end
    for (int i = 0; i < 9; i++) begin
      v = obs_col.pop_front(); e = exp_col.pop_front(); t[i] = obs_colt.pop_front();
      n_vec++;
      if (v !== e) begin
        n_err++;
        $display("FAIL scan_order%0d: got %b, want %b", i, v, e);
      end
    end
    n_vec++;
    if (t[2] - t[0] !== COL_PERIOD || t[8] - t[6] !== COL_PERIOD) begin
      n_err++;
      $display("FAIL col_period: got %0d and %0d, want %0d", t[2] - t[0], t[8] - t[6], COL_PERIOD);
    end
    fs0 = obs_fs[0]; fs1 = obs_fs[1];
    n_vec++;
    if (fs1 - fs0 !== FRAME_PERIOD || obs_fs.size() !== 2) begin
      n_err++;
      $display("FAIL frame_period: got %0d (%0d pulses), want %0d (2 pulses)", fs1 - fs0, obs_fs.size(), FRAME_PERIOD);
    end
    n_vec++;
    if (t[0] - fs0 !== LOAD_TO_HOLD || t[8] - fs1 !== LOAD_TO_HOLD) begin
      n_err++;
      $display("FAIL frame_start_pos: got %0d and %0d, want %0d", t[0] - fs0, t[8] - fs1, LOAD_TO_HOLD);
    end
  endtask

  task automatic test_snapshot();
    bit ok;
    logic [23:0] w, e;
    restart(24'h123456, 24'h000000, 24'hABCDEF, 24'h0F0F0F);
    exp_word.push_back(24'h123456); exp_word.push_back(24'h000000);
    exp_word.push_back(24'hABCDEF); exp_word.push_back(24'h0F0F0F);
    exp_word.push_back(24'h123456); exp_word.push_back(24'hFFFFFF);
    wait_for(2, 1, 10, ok);
    repeat (20) @(negedge clk);
    column_1 = 24'hFFFFFF;
    wait_for(0, 6, 2 * FRAME_PERIOD, ok);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL snap_timeout: got %0d words, want 6", obs_word.size());
    end
    for (int i = 0; i < 6 && obs_word.size() > 0; i++) begin
      w = obs_word.pop_front(); e = exp_word.pop_front();
      n_vec++;
      if (w !== e) begin
        n_err++;
        $display("FAIL snap_word%0d: got %h, want %h", i, w, e);
      end
    end
  endtask

  task automatic test_disable();
    bit ok;
    int r, nfs;
    logic [23:0] w, e;
    restart(24'h111111, 24'h222222, 24'h333333, 24'h444444);
    exp_word.push_back(24'h111111); exp_word.push_back(24'h222222); exp_word.push_back(24'h333333);
    wait_for(0, 2, 2 * COL_PERIOD + 20, ok);
    repeat (30) @(negedge clk);
    scan_en = 1'b0;
    wait_for(1, 6, COL_PERIOD + 20, ok);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL disable_timeout: got %0d enable changes, want 6", obs_col.size());
    end else begin
      n_vec++;
      if (obs_col[4] !== 4'b1011 || obs_col[5] !== 4'hF || obs_colt[5] - obs_colt[4] !== HOLD_CYCLES) begin
        n_err++;
        $display("FAIL disable_hold: got %b then %b after %0d, want 1011 then 1111 after %0d",
                 obs_col[4], obs_col[5], obs_colt[5] - obs_colt[4], HOLD_CYCLES);
      end
    end
    r = total_rises;
    repeat (300) @(negedge clk);
    n_vec++;
    if (total_rises !== r || obs_word.size() !== 3 || col_en_n !== 4'hF) begin
      n_err++;
      $display("FAIL disable_idle: got %0d extra edges, %0d words, col=%b; want 0, 3, 1111",
               total_rises - r, obs_word.size(), col_en_n);
    end
    while (obs_word.size() > 0 && exp_word.size() > 0) begin
      w = obs_word.pop_front(); e = exp_word.pop_front();
      n_vec++;
      if (w !== e) begin
        n_err++;
        $display("FAIL disable_word: got %h, want %h", w, e);
      end
    end
    obs_word.delete();
    exp_word.push_back(24'h111111);
    nfs = obs_fs.size();
    scan_en = 1'b1;
    wait_for(2, nfs + 1, 5, ok);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL reenable_frame_start: got %0d pulses, want %0d", obs_fs.size(), nfs + 1);
    end
    wait_for(0, 1, COL_PERIOD + 10, ok);
    w = ok ? obs_word.pop_front() : 24'hXXXXXX;
    e = exp_word.pop_front();
    n_vec++;
    if (w !== e) begin
      n_err++;
      $display("FAIL reenable_word: got %h, want %h", w, e);
    end
    wait_for(1, 7, 20, ok);
    n_vec++;
    if (!ok || obs_col[6] !== 4'b1110) begin
      n_err++;
      $display("FAIL reenable_column: got %b, want 1110", ok ? obs_col[6] : 4'hX);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [23:0] w, e;
    restart(24'h5A0F3C, 24'h111000, 24'h222000, 24'h333000);
    wait_for(0, 3, 3 * COL_PERIOD + 20, ok);
    repeat (30) @(negedge clk);
    n_vec++;
    if (col_en_n !== 4'b1011) begin
      n_err++;
      $display("FAIL pre_reset_column: got %b, want 1011", col_en_n);
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({col_en_n, sr_clk, sr_latch, sr_data, frame_start} !== 8'hF0) begin
      n_err++;
      $display("FAIL async_reset: got col=%b clk=%b lat=%b dat=%b fs=%b, want col=1111 others 0",
               col_en_n, sr_clk, sr_latch, sr_data, frame_start);
    end
    repeat (3) @(negedge clk);
    obs_word.delete(); obs_col.delete(); obs_colt.delete(); obs_fs.delete(); exp_word.delete();
    exp_word.push_back(24'h5A0F3C);
    rst_n = 1'b1;
    wait_for(0, 1, COL_PERIOD + 10, ok);
    w = ok ? obs_word.pop_front() : 24'hXXXXXX;
    e = exp_word.pop_front();
    n_vec++;
    if (w !== e) begin
      n_err++;
      $display("FAIL post_reset_word: got %h, want %h", w, e);
    end
    wait_for(1, 1, 20, ok);
    n_vec++;
    if (!ok || obs_col[0] !== 4'b1110) begin
      n_err++;
      $display("FAIL post_reset_column: got %b, want 1110", ok ? obs_col[0] : 4'hX);
    end
  endtask

  initial begin
    test_reset();
    test_shift_data();
    test_scan_order();
    test_snapshot();
    test_disable();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion, want finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
